dist_ram_arbiter: RTL and testbench
===================================

Name: dist_ram_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the shared single-port synchronous distributed RAM (64 x 32, registered qspo output). After reset it runs an init sweep that writes INIT_VAL to every location. It then shares the single RAM port between two requesters, e.g. fetch (port 0) and load/store (port 1), using a req/gnt handshake and returns read data with a fixed 1-cycle latency.

Parameters:
ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
DATA_W, 32, RAM data width.
INIT_EN, 1, 1 = run the zero-fill sweep after reset; 0 = enter RUN directly.
INIT_VAL, 0, value written to every location during the sweep.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req0 / req1  in  1  access request, held until granted
we0 / we1  in  1  1 = write, 0 = read; sampled with req
addr0 / addr1  in  ADDR_W  access address
wdata0 / wdata1  in  DATA_W  write data
gnt0 / gnt1  out  1  combinational grant; access occurs on this cycle's edge
rvalid0 / rvalid1  out  1  read data valid for that port
rdata  out  DATA_W  read data, shared by both ports; equals ram_qspo
init_done  out  1  high once the sweep has finished
ram_a  out  ADDR_W  RAM address
ram_d  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_qspo_ce  out  1  RAM output-register enable
ram_qspo_srst  out  1  RAM output-register synchronous reset
ram_qspo  in  DATA_W  RAM registered read data

Behaviour:
- FSM states: INIT, RUN.
- Reset entry state is INIT if INIT_EN = 1, else RUN.
- Async rst, effective immediately and also mid-access or mid-sweep:
  - state = INIT (or RUN), init_cnt = 0, rr_ptr = 0.
  - rvalid0 = rvalid1 = 0; init_done = INIT_EN ? 0 : 1.
  - Any in-flight read is dropped.
- INIT state:
  - ram_we = 1, ram_a = init_cnt, ram_d = INIT_VAL.
  - ram_qspo_ce = 0, ram_qspo_srst = 1.
  - gnt0 = gnt1 = 0; requests are ignored, not queued.
  - init_cnt increments each cycle. At init_cnt = 2**ADDR_W - 1 the state goes to RUN on the next edge and init_done becomes 1.
  - Sweep length is exactly 2**ADDR_W cycles (64 by default).
- RUN state:
  - ram_qspo_srst = 0.
  - Grant is a single-cycle combinational decision from req0, req1 and the registered rr_ptr.
  - Only req0 high: gnt0 = 1. Only req1 high: gnt1 = 1. Both high: the port equal to rr_ptr wins. Neither high: no grant.
  - The granted port's addr, wdata and we drive ram_a, ram_d and ram_we.
  - ram_qspo_ce = 1 only for a granted read. With no grant, ram_a holds 0, ram_we = 0 and ram_qspo_ce = 0, so qspo holds its last value.
  - After any grant to port k, rr_ptr <= ~k. Under continuous contention the ports alternate, so neither starves.
- Read latency:
  - A read granted in cycle N gives rvalidk = 1 in cycle N+1 only.
  - rdata = ram_qspo in cycle N+1.
  - Back-to-back reads produce back-to-back rvalid.
- Writes:
  - Commit on the grant edge; there is no response.
  - A read of the same address in the next cycle returns the new data.
- A requester holding req without gnt must keep addr, we and wdata stable.
- Only one RAM access per cycle; there is no buffering inside the block.

Decomposition:
- Shared package dist_ram_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State encodings ST_INIT = 1'b0, ST_RUN = 1'b1.
  - Port index constants P0 = 0, P1 = 1.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a registered pointer (inputs req[1:0], outputs gnt[1:0]).
- The top level holds the FSM, init counter, RAM mux and rvalid pipeline.

Test Plan:
- Init sweep: deassert rst with req held high -> ram_we = 1 for 64 cycles, ram_a walking 0..63, no gnt, init_done rising in cycle 64. A subsequent port-0 read of address 37 returns 0.
- Single port: port 0 writes 0x22 to address 2, then reads address 2 in the next cycle -> gnt0 in both cycles, rvalid0 one cycle after the read, rdata = 0x22.
- Contention: req0 and req1 held high for 6 reads (addresses 1 and 15, preloaded with 1 and 15) -> grants alternate 0,1,0,1,0,1. Each rvalid follows its grant by one cycle with the correct data.
- Mixed: port 1 writes 0xDEAD_BEEF to address 63 in the same cycle port 0 requests a read of 63, with rr_ptr = 1 -> write first, then the read is granted and returns 0xDEAD_BEEF.
- Idle hold: after a read of address 5 returns 5, drop all requests for 3 cycles -> ram_qspo_ce = 0, rdata stays 5, no rvalid.
- Reset mid-operation: assert rst during a granted read and during init_cnt = 20 -> outputs clear asynchronously, no rvalid, and the sweep restarts at address 0.

Source files
------------

// File: rtl/dist_ram_pkg.sv
// Shared constants for the distributed-RAM arbiter slice: default geometry,
// FSM state encodings and requester port indices.
package dist_ram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int P0 = 0;
  localparam int P1 = 1;

endpackage

// File: rtl/dist_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On contention the port named by the pointer
// wins, and the pointer then swings to the port that just lost.
import dist_ram_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[P0] && (!req_i[P1] || (ptr_q == 1'b0))) begin
      gnt_o[P0] = 1'b1;
    end else if (req_i[P1]) begin
      gnt_o[P1] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[P0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[P1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dist_ram_arbiter.sv
// Sequencer for a single-port distributed RAM: sweeps INIT_VAL into every
// location after reset, then shares the port between two requesters.
import dist_ram_pkg::*;

module dist_ram_arbiter #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic              ram_qspo_ce,
  output logic              ram_qspo_srst,
  input  logic [DATA_W-1:0] ram_qspo
);

  localparam logic [0:0]        RST_STATE = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        req_v;
  logic [1:0]        gnt;
  logic              run;

  assign run   = (state_q == ST_RUN);
  assign req_v = run ? {req1, req0} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_v),
    .gnt_o (gnt)
  );

  assign gnt0      = gnt[P0];
  assign gnt1      = gnt[P1];
  assign rvalid0   = rvalid_q[P0];
  assign rvalid1   = rvalid_q[P1];
  assign rdata     = ram_qspo;
  assign init_done = run;

  // With no grant the port idles at address 0 and qspo keeps its last value.
  always_comb begin
    ram_a         = '0;
    ram_d         = '0;
    ram_we        = 1'b0;
    ram_qspo_ce   = 1'b0;
    ram_qspo_srst = 1'b0;
    if (!run) begin
      ram_a         = init_cnt_q;
      ram_d         = INIT_VAL;
      ram_we        = 1'b1;
      ram_qspo_srst = 1'b1;
    end else if (gnt[P0]) begin
      ram_a       = addr0;
      ram_d       = wdata0;
      ram_we      = we0;
      ram_qspo_ce = ~we0;
    end else if (gnt[P1]) begin
      ram_a       = addr1;
      ram_d       = wdata1;
      ram_we      = we1;
      ram_qspo_ce = ~we1;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == CNT_MAX) begin
        state_d = ST_RUN;
      end
    end
  end

  assign rvalid_d = {gnt[P1] & ~we1, gnt[P0] & ~we0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_dist_ram_arbiter.sv
// Scoreboard bench for dist_ram_arbiter with a behavioural registered-output
// RAM and a reference model of the round-robin grant.
module tb_dist_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [31:0] rdata;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic        ram_we, ram_qspo_ce, ram_qspo_srst;
  logic [31:0] ram_qspo;

  dist_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
    .ram_qspo_ce(ram_qspo_ce), .ram_qspo_srst(ram_qspo_srst),
    .ram_qspo(ram_qspo)
  );

  always #5 clk = ~clk;

  logic [31:0] ramMem [64];
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_a] <= ram_d;
    if (ram_qspo_srst) ram_qspo <= '0;
    else if (ram_qspo_ce) ram_qspo <= ramMem[ram_a];
  end

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] shadow [64];
  logic        modelPtr;
  logic [31:0] modelQ;
  int          nChecks = 0;
  int          nPass = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    modelPtr = 1'b0;
    modelQ   = 32'h0;
    sbq.delete();
    sbq.push_back('{v0: 1'b0, v1: 1'b0, d: 32'h0});
  endtask

  // Called at posedge+1 with the counter at zero; walks the whole sweep.
  task automatic checkSweep();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sweep_a%0d", i), {26'h0, ram_a}, i);
      checkOutput("sweep_ctl", {ram_we, ram_qspo_srst, ram_qspo_ce, gnt0, gnt1, init_done},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    checkOutput("init_done", {31'h0, init_done}, 32'h1);
    resetModel();
  endtask

  // One RUN cycle: drive, check grants/RAM port and last cycle's response.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    logic eg0, eg1, ew, er;
    logic [5:0] ea;
    logic [31:0] ed;
    exp_t e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    eg0 = r0 && (!r1 || modelPtr == 1'b0);
    eg1 = r1 && !eg0;
    ew  = (eg0 && w0) || (eg1 && w1);
    er  = (eg0 && !w0) || (eg1 && !w1);
    ea  = eg0 ? a0 : (eg1 ? a1 : 6'd0);
    ed  = eg0 ? d0 : d1;
    checkOutput("gnt", {gnt1, gnt0}, {eg1, eg0});
    checkOutput("ram_we_ce", {ram_we, ram_qspo_ce, ram_qspo_srst}, {ew, er, 1'b0});
    checkOutput("ram_a", {26'h0, ram_a}, {26'h0, ea});
    if (ew) checkOutput("ram_d", ram_d, ed);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("rvalid", {rvalid1, rvalid0}, {e.v1, e.v0});
      checkOutput("rdata", rdata, e.d);
    end
    if (er) modelQ = shadow[ea];
    if (ew) shadow[ea] = ed;
    sbq.push_back('{v0: eg0 && !w0, v1: eg1 && !w1, d: modelQ});
    if (eg0) modelPtr = 1'b1;
    else if (eg1) modelPtr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_state", {29'h0, init_done, rvalid1, rvalid0}, 32'h0);
    rst = 1'b0;
    checkSweep();

    applyStimulus(1, 0, 6'd37, 0, 0, 0, 0, 0);
    idle(1);

    applyStimulus(1, 1, 6'd2, 32'h22, 0, 0, 0, 0);
    applyStimulus(1, 0, 6'd2, 0, 0, 0, 0, 0);
    idle(1);

    applyStimulus(1, 1, 6'd1, 32'd1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 6'd15, 32'd15);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 6'd1, 0, 1, 0, 6'd15, 0);
    idle(1);

    applyStimulus(1, 0, 6'd2, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 6'd63, 0, 1, 1, 6'd63, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 6'd63, 0, 0, 0, 0, 0);
    idle(1);

    applyStimulus(1, 1, 6'd5, 32'd5, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 6'd5, 0);
    idle(4);

    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd2; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd15;
    @(negedge clk);
    checkOutput("pre_rst_gnt", {30'h0, gnt1, gnt0}, {30'h0, 2'b01});
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst", {init_done, gnt0, gnt1, rvalid0, rvalid1, ram_qspo_srst},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    checkOutput("async_rst_a", {26'h0, ram_a}, 32'h0);
    @(posedge clk); #1;
    checkOutput("no_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("sweep_a20", {26'h0, ram_a}, 32'd20);
    #1 rst = 1'b1;
    #1;
    checkOutput("midsweep_rst_a", {26'h0, ram_a}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkSweep();

    applyStimulus(1, 0, 6'd2, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
